// File: rtl/nark_mem_pkg.sv
// Shared types and default sizing for the NARK data-memory path.
package nark_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESPOND} dmem_state_t;

  localparam int DMEM_BITS        = 24;
  localparam int DMEM_DEPTH_LOG2  = 8;
  localparam int DMEM_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_ram_array.sv
// Single-port synchronous word RAM with registered read; contents survive reset.
module dmem_ram_array
  import nark_mem_pkg::*;
#(
  parameter int BITS       = DMEM_BITS,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [BITS-1:0]       wdata,
  output logic [BITS-1:0]       rdata
);

  logic [BITS-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Handshaken multi-cycle data-memory responder for the NARK memory stage.
// Define DMEM_RANGE_CHECK_EN to flag addresses beyond the RAM depth instead of aliasing.
module data_memory_responder
  import nark_mem_pkg::*;
#(
  parameter int BITS        = DMEM_BITS,
  parameter int DEPTH_LOG2  = DMEM_DEPTH_LOG2,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic            REQ_WE,
  input  logic [BITS-1:0] REQ_ADDR,
  input  logic [BITS-1:0] REQ_WDATA,
  output logic            RSP_VALID,
  output logic [BITS-1:0] RSP_RDATA,
  output logic            RSP_ERR
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dmem_state_t     state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic            wait_done;
  logic            we_q;
  logic [BITS-1:0] addr_q, wdata_q;
  logic            addr_err;
  logic            ram_we, ram_re;
  logic            rdata_ok;
  logic [BITS-1:0] ram_rdata;

  assign wait_done = (int'(wait_cnt) == WAIT_CYCLES - 1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                           wait_cnt <= '0;
    else if (state == WAIT && !wait_done) wait_cnt <= wait_cnt + 1'b1;
    else                                wait_cnt <= '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (REQ_VALID && state == IDLE) begin
      we_q    <= REQ_WE;
      addr_q  <= REQ_ADDR;
      wdata_q <= REQ_WDATA;
    end
  end

  // The RAM read register doubles as the response data register; this flag
  // masks it to zero after reset, stores and flagged requests.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 rdata_ok <= 1'b0;
    else if (state == ACCESS) rdata_ok <= ram_re;
  end

  always_comb begin
    state_next = state;
    REQ_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    case (state)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_next = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      end
      WAIT:    if (wait_done) state_next = ACCESS;
      ACCESS:  state_next = RESPOND;
      RESPOND: begin
        RSP_VALID  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DMEM_RANGE_CHECK_EN
  assign addr_err = |addr_q[BITS-1:DEPTH_LOG2];
`else
  logic addr_hi_unused;
  assign addr_hi_unused = |addr_q[BITS-1:DEPTH_LOG2];
  assign addr_err       = 1'b0;
`endif

  assign ram_we    = (state == ACCESS) && we_q && !addr_err;
  assign ram_re    = (state == ACCESS) && !we_q && !addr_err;
  assign RSP_RDATA = rdata_ok ? ram_rdata : '0;
  assign RSP_ERR   = (state == RESPOND) && addr_err;

  dmem_ram_array #(
    .BITS       (BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q[DEPTH_LOG2-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (2 and 0 wait-state instances).
module tb_data_memory_responder;

  logic CLK = 1'b0;
  logic RST;

  logic        v2, we2, rdy2, rv2, er2;
  logic [23:0] a2, d2, rd2;
  logic        v0, we0, rdy0, rv0, er0;
  logic [23:0] a0, d0, rd0;

  logic        use0;
  logic        m_ready, m_rv, m_err;
  logic [23:0] m_rd;

  int checks = 0;
  int errors = 0;

  assign m_ready = use0 ? rdy0 : rdy2;
  assign m_rv    = use0 ? rv0  : rv2;
  assign m_err   = use0 ? er0  : er2;
  assign m_rd    = use0 ? rd0  : rd2;

  always #5 CLK = ~CLK;

  data_memory_responder #(.BITS(24), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut2 (
    .CLK(CLK), .RST(RST), .REQ_VALID(v2), .REQ_READY(rdy2), .REQ_WE(we2),
    .REQ_ADDR(a2), .REQ_WDATA(d2), .RSP_VALID(rv2), .RSP_RDATA(rd2), .RSP_ERR(er2)
  );

  data_memory_responder #(.BITS(24), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RST(RST), .REQ_VALID(v0), .REQ_READY(rdy0), .REQ_WE(we0),
    .REQ_ADDR(a0), .REQ_WDATA(d0), .RSP_VALID(rv0), .RSP_RDATA(rd0), .RSP_ERR(er0)
  );

  task automatic drive(input logic v, input logic we, input logic [23:0] a, input logic [23:0] d);
    if (use0) begin v0 = v; we0 = we; a0 = a; d0 = d; end
    else      begin v2 = v; we2 = we; a2 = a; d2 = d; end
  endtask

  // lat = number of edges after the accept edge at which RSP_VALID is seen high
  task automatic run_req(input logic we, input logic [23:0] addr, input logic [23:0] wdata,
                         output int lat, output logic [23:0] rd, output logic er,
                         output int busy, output logic vld_after, output logic rdy_after);
    int n;
    lat = -1; rd = '0; er = 1'b0; busy = 0; vld_after = 1'b0; rdy_after = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!m_ready && n < 20) begin @(negedge CLK); n++; end
    if (!m_ready) return;
    drive(1'b1, we, addr, wdata);
    @(posedge CLK);
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 1) drive(1'b0, ~we, ~addr, ~wdata);
      if (m_ready) busy++;
      if (m_rv) begin lat = i; rd = m_rd; er = m_err; break; end
    end
    if (lat > 0) begin
      @(negedge CLK);
      vld_after = m_rv;
      rdy_after = m_ready;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rdy2); end
    checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rv2); end
    checks++; if (rd2 !== 24'h0) begin errors++; $display("FAIL reset_rdata got %h want 000000", rd2); end
    checks++; if (er2 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", er2); end
    checks++;
    if ({rdy0, rv0, rd0, er0} !== {1'b1, 1'b0, 24'h0, 1'b0}) begin
      errors++; $display("FAIL reset_w0 got rdy=%b vld=%b rd=%h err=%b want 1 0 000000 0", rdy0, rv0, rd0, er0);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_store_load_w2();
    int lat, busy; logic [23:0] rd; logic er, va, ra;
    use0 = 1'b0;
    run_req(1'b1, 24'h000010, 24'hABCDEF, lat, rd, er, busy, va, ra);
    checks++; if (lat !== 4) begin errors++; $display("FAIL w2_store_lat got %0d want 4", lat); end
    checks++; if (rd !== 24'h0) begin errors++; $display("FAIL w2_store_rdata got %h want 000000", rd); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL w2_store_ready_low got %0d ready-high cycles want 0", busy); end
    checks++; if (va !== 1'b0) begin errors++; $display("FAIL w2_store_single_pulse got %b want 0", va); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL w2_store_ready_return got %b want 1", ra); end
    run_req(1'b0, 24'h000010, 24'h0, lat, rd, er, busy, va, ra);
    checks++; if (lat !== 4) begin errors++; $display("FAIL w2_load_lat got %0d want 4", lat); end
    checks++; if (rd !== 24'hABCDEF) begin errors++; $display("FAIL w2_load_rdata got %h want abcdef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL w2_load_err got %b want 0", er); end
  endtask

  task automatic test_store_load_w0();
    int lat, busy; logic [23:0] rd; logic er, va, ra;
    use0 = 1'b1;
    run_req(1'b1, 24'h0000FF, 24'h5A5A5A, lat, rd, er, busy, va, ra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL w0_store_lat got %0d want 2", lat); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL w0_store_ready_return got %b want 1", ra); end
    run_req(1'b0, 24'h0000FF, 24'h0, lat, rd, er, busy, va, ra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL w0_load_lat got %0d want 2", lat); end
    checks++; if (rd !== 24'h5A5A5A) begin errors++; $display("FAIL w0_load_rdata got %h want 5a5a5a", rd); end
    use0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, busy; logic [23:0] rd; logic er, va, ra;
    logic [23:0] want [3];
    int          pt [3];
    logic [23:0] pd [3];
    int np, idx; logic pend;
    use0 = 1'b0;
    want = '{24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C};
    pt   = '{0, 0, 0};
    pd   = '{24'h0, 24'h0, 24'h0};
    for (int i = 0; i < 3; i++) run_req(1'b1, 24'(32'h30 + i), want[i], lat, rd, er, busy, va, ra);
    np = 0; idx = 0;
    @(negedge CLK);
    drive(1'b1, 1'b0, 24'h000030, 24'h0);
    pend = m_ready;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (m_rv) begin
        if (np < 3) begin pt[np] = c; pd[np] = m_rd; end
        np++;
      end
      if (pend) begin
        idx++;
        if (idx < 3) drive(1'b1, 1'b0, 24'(32'h30 + idx), 24'h0);
        else         drive(1'b0, 1'b0, 24'h0, 24'h0);
      end
      pend = m_ready && (idx < 3);
    end
    checks++; if (np !== 3) begin errors++; $display("FAIL b2b_pulse_count got %0d want 3", np); end
    checks++; if (pt[1] - pt[0] !== 5) begin errors++; $display("FAIL b2b_spacing_01 got %0d want 5", pt[1] - pt[0]); end
    checks++; if (pt[2] - pt[1] !== 5) begin errors++; $display("FAIL b2b_spacing_12 got %0d want 5", pt[2] - pt[1]); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pd[i] !== want[i]) begin errors++; $display("FAIL b2b_rdata_%0d got %h want %h", i, pd[i], want[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int lat, busy, seen; logic [23:0] rd; logic er, va, ra;
    use0 = 1'b0;
    run_req(1'b1, 24'h000020, 24'h111111, lat, rd, er, busy, va, ra);
    run_req(1'b0, 24'h000020, 24'h0, lat, rd, er, busy, va, ra);
    checks++; if (rd !== 24'h111111) begin errors++; $display("FAIL abort_preload got %h want 111111", rd); end
    @(negedge CLK);
    drive(1'b1, 1'b1, 24'h000020, 24'h222222);
    @(posedge CLK);
    @(negedge CLK);
    drive(1'b0, 1'b0, 24'h0, 24'h0);
    checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL abort_in_wait got ready=%b want 0", rdy2); end
    checks++; if (rd2 !== 24'h111111) begin errors++; $display("FAIL abort_rdata_held got %h want 111111", rd2); end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({rdy2, rv2, rd2, er2} !== {1'b1, 1'b0, 24'h0, 1'b0}) begin
      errors++; $display("FAIL abort_async_reset got rdy=%b vld=%b rd=%h err=%b want 1 0 000000 0", rdy2, rv2, rd2, er2);
    end
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge CLK); if (rv2) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_response got %0d pulses want 0", seen); end
    run_req(1'b0, 24'h000020, 24'h0, lat, rd, er, busy, va, ra);
    checks++; if (lat !== 4) begin errors++; $display("FAIL abort_reload_lat got %0d want 4", lat); end
    checks++; if (rd !== 24'h111111) begin errors++; $display("FAIL abort_store_discarded got %h want 111111", rd); end
  endtask

  task automatic test_range();
    int lat, busy; logic [23:0] rd, rd_l, exp_l, exp_z; logic er, er_s, er_l, va, ra, exp_err;
`ifdef DMEM_RANGE_CHECK_EN
    exp_err = 1'b1; exp_l = 24'h0;      exp_z = 24'h0F0F0F;
`else
    exp_err = 1'b0; exp_l = 24'h123456; exp_z = 24'h123456;
`endif
    use0 = 1'b0;
    run_req(1'b1, 24'h000000, 24'h0F0F0F, lat, rd, er, busy, va, ra);
    run_req(1'b1, 24'h000100, 24'h123456, lat, rd, er_s, busy, va, ra);
    checks++; if (er_s !== exp_err) begin errors++; $display("FAIL range_store_err got %b want %b", er_s, exp_err); end
    run_req(1'b0, 24'h000100, 24'h0, lat, rd_l, er_l, busy, va, ra);
    checks++; if (er_l !== exp_err) begin errors++; $display("FAIL range_load_err got %b want %b", er_l, exp_err); end
    checks++; if (rd_l !== exp_l) begin errors++; $display("FAIL range_load_rdata got %h want %h", rd_l, exp_l); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL range_load_lat got %0d want 4", lat); end
    run_req(1'b0, 24'h000000, 24'h0, lat, rd, er, busy, va, ra);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL range_word0_err got %b want 0", er); end
    checks++; if (rd !== exp_z) begin errors++; $display("FAIL range_word0_rdata got %h want %h", rd, exp_z); end
  endtask

  initial begin
    use0 = 1'b0;
    v2 = 1'b0; we2 = 1'b0; a2 = '0; d2 = '0;
    v0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0;
    test_reset();
    test_store_load_w2();
    test_store_load_w0();
    test_back_to_back();
    test_reset_abort();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
